// File: rtl/branch_update_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_update_unit_pkg
// Shared definitions for the branch history table (BHT) writer side:
//   - table geometry (entry count, index width, update FIFO depth)
//   - 2-bit prediction counter encodings
//   - the update record that travels from EX to the BHT write port
//   - the saturating counter next-state helper
// ---------------------------------------------------------------------------
package branch_update_unit_pkg;

    localparam int BP_ENTRIES    = 128;
    localparam int BP_IDXW       = $clog2(BP_ENTRIES);
    localparam int BP_FIFO_DEPTH = 4;

    // Record layout, MSB to LSB: idx | pc | target | ctr
    localparam int BP_REC_W = BP_IDXW + 66;

    // Low values lean taken, so the MSB of the counter means "predict not taken"
    typedef enum logic [1:0] {
        BP_ST  = 2'b00,
        BP_WT  = 2'b01,
        BP_WNT = 2'b10,
        BP_SNT = 2'b11
    } bp_ctr_e;

    typedef struct packed {
        logic [BP_IDXW-1:0] idx;
        logic [31:0]        pc;
        logic [31:0]        target;
        logic [1:0]         ctr;
    } bp_rec_t;

    // Taken moves toward ST, not taken moves toward SNT, both saturating
    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            case (ctr)
                BP_ST:   nxt = BP_ST;
                BP_WT:   nxt = BP_ST;
                BP_WNT:  nxt = BP_WT;
                default: nxt = BP_WNT;
            endcase
        end else begin
            case (ctr)
                BP_ST:   nxt = BP_WT;
                BP_WT:   nxt = BP_WNT;
                BP_WNT:  nxt = BP_SNT;
                default: nxt = BP_SNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// ---------------------------------------------------------------------------
// bp_update_fifo
// Small synchronous FIFO that holds pending BHT update records.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   push_i, data_i  write a record; taken when not full or when popping too
//   pop_i           remove the head record; ignored when empty
//   data_o          head record, all zeros while empty
//   full_o, empty_o occupancy flags
// ---------------------------------------------------------------------------
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTRW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTRW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head is forced to zero when empty so stale records never leak out
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/branch_update_unit.sv
// ---------------------------------------------------------------------------
// branch_update_unit
// EX-stage branch resolver and BHT writer.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   res_*                      resolved branch plus the fetch-time prediction
//   redirect_valid/_pc         registered one-cycle mispredict redirect
//   upd_valid/_ready, upd_*    queued BHT write records (valid/ready)
//   br_cnt, mispred_cnt        wrapping statistics
//   drop_cnt                   saturating count of records lost to a full queue
// ---------------------------------------------------------------------------
module branch_update_unit
    import branch_update_unit_pkg::*;
#(
    parameter int ENTRIES    = BP_ENTRIES,
    parameter int FIFO_DEPTH = BP_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               res_valid,
    input  logic [31:0]        res_pc,
    input  logic [31:0]        res_pcplus4,
    input  logic               res_taken,
    input  logic [31:0]        res_target,
    input  logic               res_hit,
    input  logic [BP_IDXW-1:0] res_idx,
    input  logic [1:0]         res_ctr,
    input  logic [31:0]        res_pred_tgt,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [BP_IDXW-1:0] upd_idx,
    output logic [31:0]        upd_pc,
    output logic [31:0]        upd_target,
    output logic [1:0]         upd_ctr,
    output logic [31:0]        br_cnt,
    output logic [31:0]        mispred_cnt,
    output logic [15:0]        drop_cnt
);

    logic               pred_taken;
    logic               mispredict;
    logic               push_req, push_ok, pop, drop;
    logic               fifo_full, fifo_empty;
    bp_rec_t            rec_in, rec_head;

    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q,    redirect_pc_d;
    logic [BP_IDXW-1:0] alloc_ptr_q,      alloc_ptr_d;
    logic [31:0]        br_cnt_q,         br_cnt_d;
    logic [31:0]        mispred_cnt_q,    mispred_cnt_d;
    logic [15:0]        drop_cnt_q,       drop_cnt_d;

    // A taken prediction that pointed at the wrong target is also a mispredict
    assign pred_taken = res_hit & ~res_ctr[1];
    assign mispredict = res_valid &
                        ((pred_taken != res_taken) |
                         (pred_taken & res_taken & (res_pred_tgt != res_target)));

    // Hits update their own line; only taken misses are worth allocating
    always_comb begin
        rec_in   = '0;
        push_req = 1'b0;
        if (res_valid) begin
            if (res_hit) begin
                push_req      = 1'b1;
                rec_in.idx    = res_idx;
                rec_in.pc     = res_pc;
                rec_in.target = res_taken ? res_target : res_pred_tgt;
                rec_in.ctr    = bp_ctr_next(res_ctr, res_taken);
            end else if (res_taken) begin
                push_req      = 1'b1;
                rec_in.idx    = alloc_ptr_q;
                rec_in.pc     = res_pc;
                rec_in.target = res_target;
                rec_in.ctr    = BP_ST;
            end
        end
    end

    assign pop     = ~fifo_empty & upd_ready;
    assign push_ok = push_req & (~fifo_full | pop);
    assign drop    = push_req & ~push_ok;

    bp_update_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BP_REC_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_ok),
        .pop_i   (pop),
        .data_i  (rec_in),
        .data_o  (rec_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The allocation pointer only moves when its record actually entered the queue
    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = '0;
        alloc_ptr_d      = alloc_ptr_q;
        br_cnt_d         = br_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        drop_cnt_d       = drop_cnt_q;

        if (mispredict) begin
            redirect_pc_d = res_taken ? res_target : res_pcplus4;
        end
        if (push_ok & ~res_hit) begin
            alloc_ptr_d = (alloc_ptr_q == BP_IDXW'(ENTRIES-1)) ? '0 : alloc_ptr_q + 1'b1;
        end
        if (res_valid) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (mispredict) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            alloc_ptr_q      <= '0;
            br_cnt_q         <= '0;
            mispred_cnt_q    <= '0;
            drop_cnt_q       <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            alloc_ptr_q      <= alloc_ptr_d;
            br_cnt_q         <= br_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
            drop_cnt_q       <= drop_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign upd_valid      = ~fifo_empty;
    assign upd_idx        = rec_head.idx;
    assign upd_pc         = rec_head.pc;
    assign upd_target     = rec_head.target;
    assign upd_ctr        = rec_head.ctr;
    assign br_cnt         = br_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_branch_update_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_update_unit
// Directed bench for branch_update_unit: prediction outcomes, counter update
// table, allocation and wrap, queue full/drop behaviour, and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_branch_update_unit;

    logic        clk;
    logic        reset;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_pcplus4;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_hit;
    logic [6:0]  res_idx;
    logic [1:0]  res_ctr;
    logic [31:0] res_pred_tgt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [6:0]  upd_idx;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  upd_ctr;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    branch_update_unit dut (
        .clk            (clk),
        .reset          (reset),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_pcplus4    (res_pcplus4),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_hit        (res_hit),
        .res_idx        (res_idx),
        .res_ctr        (res_ctr),
        .res_pred_tgt   (res_pred_tgt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_idx        (upd_idx),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_ctr        (upd_ctr),
        .br_cnt         (br_cnt),
        .mispred_cnt    (mispred_cnt),
        .drop_cnt       (drop_cnt)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one resolved-branch cycle; fall-through is always pc + 4
    task automatic applyStimulus(input logic valid, input logic hit, input logic taken,
                                 input logic [6:0] idx, input logic [1:0] ctr,
                                 input logic [31:0] pc, input logic [31:0] target,
                                 input logic [31:0] predTgt, input logic ready);
        res_valid    = valid;
        res_hit      = hit;
        res_taken    = taken;
        res_idx      = idx;
        res_ctr      = ctr;
        res_pc       = pc;
        res_pcplus4  = pc + 32'd4;
        res_target   = target;
        res_pred_tgt = predTgt;
        upd_ready    = ready;
    endtask

    // Advance to just after the next rising edge so outputs are settled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Synchronous-looking reset pulse between test groups
    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkOutput("rst_br_cnt", br_cnt, 32'd0);
        checkOutput("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
        checkOutput("reset_upd_valid", {31'd0, upd_valid}, 32'd0);
        checkOutput("reset_upd_idx", {25'd0, upd_idx}, 32'd0);
        checkOutput("reset_mispred_cnt", mispred_cnt, 32'd0);
        checkOutput("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Miss, taken: allocate line 0, redirect to target
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h40, 32'h80, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        checkOutput("t1_redirect_pc", redirect_pc, 32'h80);
        checkOutput("t1_upd_valid", {31'd0, upd_valid}, 32'd1);
        checkOutput("t1_upd_idx", {25'd0, upd_idx}, 32'd0);
        checkOutput("t1_upd_ctr", {30'd0, upd_ctr}, 32'd0);
        checkOutput("t1_upd_pc", upd_pc, 32'h40);
        checkOutput("t1_upd_target", upd_target, 32'h80);
        checkOutput("t1_br_cnt", br_cnt, 32'd1);
        checkOutput("t1_mispred_cnt", mispred_cnt, 32'd1);
        tick();
        checkOutput("t1_drain_valid", {31'd0, upd_valid}, 32'd0);
        checkOutput("t1_drain_pc", upd_pc, 32'd0);
        checkOutput("t1_redirect_clear", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t1_redirect_pc_clear", redirect_pc, 32'd0);

        // Hit ST, not taken: mispredict to fall-through, ctr 00 -> 01
        applyStimulus(1'b1, 1'b1, 1'b0, 7'd5, 2'b00, 32'h40, 32'h80, 32'h80, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        checkOutput("t2_redirect_pc", redirect_pc, 32'h44);
        checkOutput("t2_upd_idx", {25'd0, upd_idx}, 32'd5);
        checkOutput("t2_upd_ctr", {30'd0, upd_ctr}, 32'd1);
        checkOutput("t2_upd_target", upd_target, 32'h80);
        checkOutput("t2_mispred_cnt", mispred_cnt, 32'd2);
        tick();

        // Hit SNT, not taken: correct, counter saturates at 11
        applyStimulus(1'b1, 1'b1, 1'b0, 7'd9, 2'b11, 32'h50, 32'h90, 32'h300, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t3_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t3_redirect_pc", redirect_pc, 32'd0);
        checkOutput("t3_upd_idx", {25'd0, upd_idx}, 32'd9);
        checkOutput("t3_upd_ctr", {30'd0, upd_ctr}, 32'd3);
        checkOutput("t3_upd_target", upd_target, 32'h300);
        checkOutput("t3_br_cnt", br_cnt, 32'd3);
        checkOutput("t3_mispred_cnt", mispred_cnt, 32'd2);
        tick();

        // Hit ST, taken to the predicted target: correct, counter stays 00
        applyStimulus(1'b1, 1'b1, 1'b1, 7'd3, 2'b00, 32'h58, 32'h400, 32'h400, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t3b_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t3b_upd_ctr", {30'd0, upd_ctr}, 32'd0);
        checkOutput("t3b_mispred_cnt", mispred_cnt, 32'd2);
        tick();

        // Hit WT, taken to a different target: target mispredict
        applyStimulus(1'b1, 1'b1, 1'b1, 7'd12, 2'b01, 32'h60, 32'h200, 32'h100, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t4_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        checkOutput("t4_redirect_pc", redirect_pc, 32'h200);
        checkOutput("t4_upd_target", upd_target, 32'h200);
        checkOutput("t4_upd_ctr", {30'd0, upd_ctr}, 32'd0);
        checkOutput("t4_mispred_cnt", mispred_cnt, 32'd3);
        tick();

        // Hit WNT, taken: direction mispredict, ctr 10 -> 01
        applyStimulus(1'b1, 1'b1, 1'b1, 7'd20, 2'b10, 32'h70, 32'h500, 32'h500, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t4b_redirect_pc", redirect_pc, 32'h500);
        checkOutput("t4b_upd_ctr", {30'd0, upd_ctr}, 32'd1);
        checkOutput("t4b_br_cnt", br_cnt, 32'd6);
        tick();

        // Miss, not taken: nothing queued, allocation pointer untouched
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 32'h80, 32'h600, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("t4c_upd_valid", {31'd0, upd_valid}, 32'd0);
        checkOutput("t4c_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("t4c_br_cnt", br_cnt, 32'd7);
        checkOutput("t4c_mispred_cnt", mispred_cnt, 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h90, 32'h700, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t4c_alloc_idx", {25'd0, upd_idx}, 32'd1);
        checkOutput("t4c_mispred_after", mispred_cnt, 32'd5);
        tick();

        // Queue full with write port stalled: 4 kept, 2 dropped
        pulseReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h1000 + 32'(4*i),
                          32'h2000 + 32'(4*i), 32'h0, 1'b0);
            tick();
            if (i == 3) begin
                checkOutput("t5_head_at_full", {25'd0, upd_idx}, 32'd0);
                checkOutput("t5_drop_at_full", {16'd0, drop_cnt}, 32'd0);
            end
        end
        checkOutput("t5_drop_cnt", {16'd0, drop_cnt}, 32'd2);
        checkOutput("t5_head_stable_idx", {25'd0, upd_idx}, 32'd0);
        checkOutput("t5_head_stable_pc", upd_pc, 32'h1000);
        checkOutput("t5_br_cnt", br_cnt, 32'd6);
        checkOutput("t5_redirect_pc", redirect_pc, 32'h2014);
        // Push into a full queue while the head drains: accepted, takes idx 4
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h1018, 32'h2018, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t5_pushpop_head", {25'd0, upd_idx}, 32'd1);
        checkOutput("t5_pushpop_drop", {16'd0, drop_cnt}, 32'd2);
        for (int k = 2; k <= 4; k++) begin
            tick();
            checkOutput("t5_drain_idx", {25'd0, upd_idx}, 32'(k));
        end
        checkOutput("t5_drain_last_pc", upd_pc, 32'h1018);
        tick();
        checkOutput("t5_drained_empty", {31'd0, upd_valid}, 32'd0);

        // Allocation pointer wraps after 128 accepted allocations
        pulseReset();
        for (int i = 0; i < 128; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h3000 + 32'(4*i),
                          32'h8000, 32'h0, 1'b1);
            tick();
            checkOutput("t6_alloc_idx", {25'd0, upd_idx}, 32'(i));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h4000, 32'h8000, 32'h0, 1'b1);
        tick();
        checkOutput("t6_wrap_idx", {25'd0, upd_idx}, 32'd0);
        checkOutput("t6_br_cnt", br_cnt, 32'd129);
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h4004, 32'h8000, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("t6_pending_valid", {31'd0, upd_valid}, 32'd1);

        // Asynchronous reset mid-drain takes effect before the next edge
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_upd_valid", {31'd0, upd_valid}, 32'd0);
        checkOutput("t6_async_upd_idx", {25'd0, upd_idx}, 32'd0);
        checkOutput("t6_async_br_cnt", br_cnt, 32'd0);
        checkOutput("t6_async_mispred", mispred_cnt, 32'd0);
        checkOutput("t6_async_redirect", {31'd0, redirect_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd0, 2'd0, 32'h5000, 32'h9000, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t6_post_reset_idx", {25'd0, upd_idx}, 32'd0);
        checkOutput("t6_post_reset_pc", upd_pc, 32'h5000);
        checkOutput("t6_post_reset_br", br_cnt, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
